// File: rtl/tech_ram_fifo_if.sv
// tech_ram_fifo_if: write and read valid/ready streams of tech_ram_fifo.
interface tech_ram_fifo_if #(parameter int DATA_WIDTH = 32);
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [DATA_WIDTH-1:0] wr_dat_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [DATA_WIDTH-1:0] rd_dat_o;
  modport slave (input wr_valid_i, wr_dat_i, rd_ready_i, output wr_ready_o, rd_valid_o, rd_dat_o);
  modport master (output wr_valid_i, wr_dat_i, rd_ready_i, input wr_ready_o, rd_valid_o, rd_dat_o);
endinterface

// File: rtl/tech_ram_fifo.sv
// tech_ram_fifo: FIFO over one single-port RAM with a 2-entry output stage.
// Optional RAM_FIFO_FLUSH_EN adds flush_i, which clears all state like reset.
module tech_ram_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 3)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef RAM_FIFO_FLUSH_EN
  input  logic                  flush_i,
`endif
  tech_ram_fifo_if.slave        s,
  output logic [CW-1:0]         cnt_o,
  output logic                  ram_en_o,
  output logic                  ram_wen_o,
  output logic [AW-1:0]         ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_dat_o,
  input  logic [DATA_WIDTH-1:0] ram_dat_i
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_ram_cnt, r_cnt, w_ram_cnt_n;
  logic                  r_inflight;
  logic [1:0]            r_stage_cnt, w_stage_cnt_n, w_occ;
  logic [DATA_WIDTH-1:0] r_s0, r_s1;
  logic                  w_clr, w_rd, w_wr, w_pop;
`ifdef RAM_FIFO_FLUSH_EN
  assign w_clr = rst_i || flush_i;
`else
  assign w_clr = rst_i;
`endif
  // Reads take priority only when the output side would otherwise starve or the RAM is full
  always_comb begin
    w_occ = r_stage_cnt + {1'b0, r_inflight};
    w_rd = !w_clr && r_ram_cnt != '0 && w_occ < 2'd2 &&
           (w_occ == 2'd0 || !s.wr_valid_i || r_ram_cnt == FULL);
    w_wr = !w_clr && !w_rd && s.wr_valid_i && r_ram_cnt != FULL;
    w_pop = r_stage_cnt != 2'd0 && s.rd_ready_i;
    w_ram_cnt_n = r_ram_cnt + CW'(w_wr) - CW'(w_rd);
    w_stage_cnt_n = r_stage_cnt + 2'(r_inflight) - 2'(w_pop);
  end
  assign s.wr_ready_o = !w_clr && r_ram_cnt != FULL && !w_rd;
  assign s.rd_valid_o = r_stage_cnt != 2'd0;
  assign s.rd_dat_o   = r_s0;
  assign cnt_o        = r_cnt;
  assign ram_en_o     = !(w_rd || w_wr);
  assign ram_wen_o    = !w_wr;
  assign ram_addr_o   = w_wr ? r_wr_ptr : w_rd ? r_rd_ptr : '0;
  assign ram_dat_o    = w_wr ? s.wr_dat_i : '0;
  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_cnt   <= '0;
      r_cnt       <= '0;
      r_inflight  <= 1'b0;
      r_stage_cnt <= 2'd0;
      r_s0        <= '0;
      r_s1        <= '0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + AW'(w_wr);
      r_rd_ptr    <= r_rd_ptr + AW'(w_rd);
      r_ram_cnt   <= w_ram_cnt_n;
      r_inflight  <= w_rd;
      r_stage_cnt <= w_stage_cnt_n;
      r_cnt       <= w_ram_cnt_n + CW'(w_rd) + CW'(w_stage_cnt_n);
      // ram_dat_i is only meaningful the cycle after a read issue
      if (r_inflight && (r_stage_cnt == 2'd0 || (w_pop && r_stage_cnt == 2'd1)))
        r_s0 <= ram_dat_i;
      else if (w_pop && r_stage_cnt == 2'd2)
        r_s0 <= r_s1;
      if (r_inflight && (w_pop ? r_stage_cnt == 2'd2 : r_stage_cnt == 2'd1))
        r_s1 <= ram_dat_i;
    end
  end
endmodule

// File: tb/tb_tech_ram_fifo.sv
// tb_tech_ram_fifo: directed table plus fill, stream, reset and flush sequences.
module tb_tech_ram_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  cnt;
  logic        ram_en, ram_wen;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdat, ram_q;
  logic [31:0] mem [64];
`ifdef RAM_FIFO_FLUSH_EN
  logic        flush = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  tech_ram_fifo_if #(.DATA_WIDTH(32)) f();
  tech_ram_fifo #(.DATA_WIDTH(32), .DEPTH(64)) dut (
    .clk_i(clk), .rst_i(rst),
`ifdef RAM_FIFO_FLUSH_EN
    .flush_i(flush),
`endif
    .s(f), .cnt_o(cnt), .ram_en_o(ram_en), .ram_wen_o(ram_wen),
    .ram_addr_o(ram_addr), .ram_dat_o(ram_wdat), .ram_dat_i(ram_q));
  always #5 clk = ~clk;
  // Single-port RAM model: read data one cycle later, garbage otherwise
  always @(posedge clk) begin
    if (!ram_en && !ram_wen) mem[ram_addr] <= ram_wdat;
    ram_q <= (!ram_en && ram_wen) ? mem[ram_addr] : $urandom;
  end
  typedef struct {
    logic wv; logic [31:0] wd; logic rr;
    logic ev; logic [31:0] ed; logic [6:0] ec; logic ewr; logic een;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  initial begin
    int n, e, wi, ri;
    logic found;
    tbl[0]  = '{1'b1, 32'hA5A50001, 1'b1, 1'b0, 32'h0,        7'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        7'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        7'd1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hA5A50001, 7'd1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        7'd0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 32'h11,       1'b0, 1'b0, 32'h0,        7'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 32'h22,       1'b0, 1'b0, 32'h0,        7'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 32'h22,       1'b0, 1'b0, 32'h0,        7'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 32'h33,       1'b0, 1'b1, 32'h11,       7'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h11,       7'd3, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h11,       7'd3, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h22,       7'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        7'd1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h33,       7'd1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        7'd0, 1'b1, 1'b1};
    rst = 1'b1;
    f.wr_valid_i = 1'b1;
    f.wr_dat_i = 32'hDEAD;
    f.rd_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", {31'b0, f.wr_ready_o}, 32'd0);
    chk("rst_ram_en", {31'b0, ram_en}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    f.wr_valid_i = 1'b0;
    #1;
    chk("rst_rd_valid", {31'b0, f.rd_valid_o}, 32'd0);
    chk("rst_rd_dat", f.rd_dat_o, 32'd0);
    chk("rst_cnt", {25'b0, cnt}, 32'd0);
    chk("rst_ram_en_rel", {31'b0, ram_en}, 32'd1);
    chk("rst_ram_addr", {26'b0, ram_addr}, 32'd0);
    chk("rst_wr_ready_rel", {31'b0, f.wr_ready_o}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      f.wr_valid_i = tbl[i].wv;
      f.wr_dat_i = tbl[i].wd;
      f.rd_ready_i = tbl[i].rr;
      #1;
      chk($sformatf("v%0d_rd_valid", i), {31'b0, f.rd_valid_o}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) chk($sformatf("v%0d_rd_dat", i), f.rd_dat_o, tbl[i].ed);
      chk($sformatf("v%0d_cnt", i), {25'b0, cnt}, {25'b0, tbl[i].ec});
      chk($sformatf("v%0d_wr_ready", i), {31'b0, f.wr_ready_o}, {31'b0, tbl[i].ewr});
      chk($sformatf("v%0d_ram_en", i), {31'b0, ram_en}, {31'b0, tbl[i].een});
    end
    // Fill to DEPTH+2 with the consumer stalled, then drain
    n = 0;
    for (int c = 0; c < 400 && n < 66; c++) begin
      @(negedge clk);
      f.wr_valid_i = 1'b1;
      f.wr_dat_i = n;
      f.rd_ready_i = 1'b0;
      #1;
      if (f.wr_ready_o) n++;
    end
    chk("fill_accepted", n, 32'd66);
    @(negedge clk);
    #1;
    chk("full_wr_ready", {31'b0, f.wr_ready_o}, 32'd0);
    chk("full_cnt", {25'b0, cnt}, 32'd66);
    e = 0;
    for (int c = 0; c < 400 && e < 66; c++) begin
      @(negedge clk);
      f.wr_valid_i = 1'b0;
      f.rd_ready_i = 1'b1;
      #1;
      if (f.rd_valid_o) begin
        chk($sformatf("drain_%0d", e), f.rd_dat_o, e);
        e++;
      end
    end
    chk("drain_count", e, 32'd66);
    @(negedge clk);
    #1;
    chk("drain_cnt", {25'b0, cnt}, 32'd0);
    // Random stream with scoreboard; a write handshake must be exactly a RAM write
    wi = 0;
    ri = 0;
    for (int c = 0; c < 5000 && ri < 200; c++) begin
      @(negedge clk);
      f.wr_valid_i = (wi < 200) && $urandom_range(1, 0) == 1;
      f.wr_dat_i = 1000 + wi;
      f.rd_ready_i = $urandom_range(1, 0) == 1;
      #1;
      chk("stream_wr_op", {31'b0, f.wr_valid_i && f.wr_ready_o}, {31'b0, !ram_en && !ram_wen});
      if (f.wr_valid_i && f.wr_ready_o) wi++;
      if (f.rd_valid_o && f.rd_ready_i) begin
        chk("stream_dat", f.rd_dat_o, 1000 + ri);
        ri++;
      end
    end
    chk("stream_count", ri, 32'd200);
    @(negedge clk);
    f.wr_valid_i = 1'b0;
    #1;
    chk("stream_cnt", {25'b0, cnt}, 32'd0);
    // Reset with 10 words held
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      f.wr_valid_i = 1'b1;
      f.wr_dat_i = 32'h7000 + n;
      f.rd_ready_i = 1'b0;
      #1;
      if (f.wr_ready_o) n++;
    end
    @(negedge clk);
    f.wr_valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_cnt_held", {25'b0, cnt}, 32'd10);
    @(negedge clk);
    rst = 1'b1;
    f.wr_valid_i = 1'b1;
    f.wr_dat_i = 32'hBAD0;
    #1;
    chk("mid_rst_ram_en", {31'b0, ram_en}, 32'd1);
    chk("mid_rst_wr_ready", {31'b0, f.wr_ready_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    f.wr_valid_i = 1'b0;
    #1;
    chk("mid_cnt", {25'b0, cnt}, 32'd0);
    chk("mid_rd_valid", {31'b0, f.rd_valid_o}, 32'd0);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      f.wr_valid_i = 1'b1;
      f.wr_dat_i = 32'h1234;
      f.rd_ready_i = 1'b1;
      #1;
      if (f.wr_ready_o) found = 1'b1;
    end
    @(negedge clk);
    f.wr_valid_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      #1;
      if (f.rd_valid_o) begin
        found = 1'b1;
        chk("mid_first_dat", f.rd_dat_o, 32'h1234);
      end
    end
    chk("mid_first_seen", {31'b0, found}, 32'd1);
`ifdef RAM_FIFO_FLUSH_EN
    // Flush with 5 words held and a read in flight
    @(negedge clk);
    f.rd_ready_i = 1'b1;
    @(negedge clk);
    n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      f.wr_valid_i = 1'b1;
      f.wr_dat_i = 32'h500 + n;
      f.rd_ready_i = 1'b0;
      #1;
      if (f.wr_ready_o) n++;
    end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      f.wr_valid_i = 1'b0;
      #1;
      if (!ram_en && ram_wen) found = 1'b1;
    end
    chk("fl_read_issued", {31'b0, found}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    f.wr_valid_i = 1'b1;
    f.wr_dat_i = 32'hBAD1;
    #1;
    chk("fl_held", {25'b0, cnt}, 32'd5);
    chk("fl_ram_en", {31'b0, ram_en}, 32'd1);
    chk("fl_wr_ready", {31'b0, f.wr_ready_o}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    f.wr_valid_i = 1'b0;
    f.rd_ready_i = 1'b1;
    #1;
    chk("fl_cnt", {25'b0, cnt}, 32'd0);
    chk("fl_rd_valid", {31'b0, f.rd_valid_o}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("fl_stale", {31'b0, f.rd_valid_o}, 32'd0);
    end
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      f.wr_valid_i = 1'b1;
      f.wr_dat_i = 32'h5678;
      #1;
      if (f.wr_ready_o) found = 1'b1;
    end
    @(negedge clk);
    f.wr_valid_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      #1;
      if (f.rd_valid_o) begin
        found = 1'b1;
        chk("fl_first_dat", f.rd_dat_o, 32'h5678);
      end
    end
    chk("fl_first_seen", {31'b0, found}, 32'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
